// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the SimpleRISC pipeline.
//
// Owns the PC and drives a synchronous instruction memory that returns data
// one cycle after the read is issued. A one-entry skid buffer catches the
// response that is already in flight when a downstream stall arrives, so the
// stream resumes without a bubble. It redirects on taken branches, freezes
// after fetching a halt word (opcode 5'b11111), and inserts NOP bubbles when
// nothing real is available.
//
// Optional build macro FETCH_PERF_EN adds two free-running performance
// counters (perf_fetched, perf_bubbles).
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         synchronous, active-high reset
//   stall         hold IF/OF latch and PC (downstream interlock)
//   isBranchTaken redirect/flush request from execute (beats stall and halt)
//   branchPC      redirect target, used as-is
//   imem_addr     instruction memory read address (= internal PC)
//   imem_en       read issue strobe; data returns next cycle
//   imem_data     read data for the address issued the previous cycle
//   inst/pc/valid IF/OF latch (valid=0 marks a bubble)
//   halted        fetch frozen after a halt
//   perf_fetched  (FETCH_PERF_EN) edges where a valid inst entered the latch
//   perf_bubbles  (FETCH_PERF_EN) unstalled edges where a bubble was latched
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_INST = 32'h6800_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        isBranchTaken,
  input  logic [31:0] branchPC,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_reg, state_next;

  logic [31:0] pc_reg;          // next fetch address
  logic        req_valid_reg;   // a read was issued last cycle
  logic [31:0] req_pc_reg;      // address of that read
  logic        skid_valid_reg;
  logic [31:0] skid_inst_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] pc_out_reg;
  logic        valid_reg;

  // Word that would enter the latch this edge. The skid always holds the
  // older word, so it takes precedence over a live response.
  logic        load_any;
  logic [31:0] load_inst;
  logic [31:0] load_pc;
  logic        halt_load;

  assign load_inst = skid_valid_reg ? skid_inst_reg : imem_data;
  assign load_pc   = skid_valid_reg ? skid_pc_reg   : req_pc_reg;
  assign load_any  = ~isBranchTaken & ~stall & (skid_valid_reg | req_valid_reg);
  assign halt_load = load_any & (load_inst[31:27] == 5'b11111);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (isBranchTaken)  state_next = RUN;
    else if (halt_load) state_next = HALT;
  end

  // Output logic
  always_comb begin
    halted  = (state_reg == HALT);
    imem_en = (state_reg == RUN) & ~stall & ~isBranchTaken;
  end

  assign imem_addr = pc_reg;
  assign inst      = inst_reg;
  assign pc        = pc_out_reg;
  assign valid     = valid_reg;

  // PC, request tracking, skid buffer and IF/OF latch
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      req_valid_reg  <= 1'b0;
      req_pc_reg     <= 32'h0;
      skid_valid_reg <= 1'b0;
      skid_inst_reg  <= 32'h0;
      skid_pc_reg    <= 32'h0;
      inst_reg       <= NOP_INST;
      pc_out_reg     <= 32'h0;
      valid_reg      <= 1'b0;
    end else if (isBranchTaken) begin
      // Flush everything in flight; the redirected read issues next cycle.
      pc_reg         <= branchPC;
      req_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      inst_reg       <= NOP_INST;
      valid_reg      <= 1'b0;
    end else begin
      if (imem_en) begin
        req_valid_reg <= 1'b1;
        req_pc_reg    <= pc_reg;
        pc_reg        <= pc_reg + PC_STEP;
      end else begin
        req_valid_reg <= 1'b0;
      end

      if (stall) begin
        // No read issues while stalled, so at most one response lands here.
        if (req_valid_reg) begin
          skid_valid_reg <= 1'b1;
          skid_inst_reg  <= imem_data;
          skid_pc_reg    <= req_pc_reg;
        end
      end else begin
        if (load_any) begin
          inst_reg       <= load_inst;
          pc_out_reg     <= load_pc;
          valid_reg      <= 1'b1;
          skid_valid_reg <= 1'b0;
        end else begin
          inst_reg  <= NOP_INST;
          valid_reg <= 1'b0;
        end
        // A halt parks the PC just past itself and drops the read issued
        // alongside it, so nothing younger than the halt ever reaches the latch.
        if (halt_load) begin
          pc_reg        <= load_pc + PC_STEP;
          req_valid_reg <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_bubbles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= 32'h0;
      perf_bubbles_reg <= 32'h0;
    end else if (~stall) begin
      if (load_any) perf_fetched_reg <= perf_fetched_reg + 32'd1;
      else          perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule
